// File: rtl/stack_pkg.sv
// Shared types, register indices and list helpers for the PUSH/POP sequencer.
package stack_pkg;

  localparam int DEF_WORD_BYTES = 4;

  localparam logic [3:0] REG_LR = 4'hE;
  localparam logic [3:0] REG_SP = 4'hD;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD   = 3'd1;
  localparam state_t S_RDW  = 3'd2;
  localparam state_t S_MEM  = 3'd3;
  localparam state_t S_WB   = 3'd4;
  localparam state_t S_SPU  = 3'd5;
  localparam state_t S_DONE = 3'd6;

  // Bit position (0..8) of the lowest set bit; 0 for an empty list.
  function automatic logic [3:0] lowest_set(input logic [8:0] v);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) pos = 4'(i);
    end
    return pos;
  endfunction

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/stack_list_pick.sv
// Priority pick of the next register from the remaining list: lowest bit first,
// bit 8 maps to LR/PC. Purely combinational.
module stack_list_pick
  import stack_pkg::*;
(
  input  logic [8:0] list_rem,
  output logic [3:0] idx,
  output logic [8:0] clr_mask
);

  logic [3:0] pos;

  always_comb begin
    pos      = lowest_set(list_rem);
    clr_mask = (list_rem != 9'd0) ? (9'd1 << pos) : 9'd0;
    idx      = (pos == 4'd8) ? REG_LR : pos;
  end

endmodule

// File: rtl/stack_seq.sv
// Multi-cycle PUSH/POP sequencer feeding the register file and data-memory port.
// Optional STACK_ALIGN_CHECK_EN rejects a misaligned SP and adds fault_o.
module stack_seq
  import stack_pkg::*;
#(
  parameter int AW         = 32,
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
`ifdef STACK_ALIGN_CHECK_EN
  output logic          fault_o,
`endif
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          is_push_i,
  input  logic [7:0]    reg_list_i,
  input  logic          extra_i,
  input  logic [31:0]   sp_i,
  input  logic [31:0]   rd_data_i,
  output logic [3:0]    rd_sel_o,
  output logic          wr_en_o,
  output logic [3:0]    wr_sel_o,
  output logic [31:0]   wr_data_o,
  output logic          sp_we_o,
  output logic [31:0]   sp_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          pc_load_o,
  output logic [31:0]   pc_o,
  output logic          busy_o,
  output logic          done_o
);

  state_t        state;
  logic [8:0]    list;
  logic [3:0]    cnt;
  logic          is_push;
  logic [AW-1:0] addr;
  logic [31:0]   sp_base;
  logic [31:0]   data;

  logic [8:0]    start_list;
  logic [3:0]    start_cnt;
  logic [31:0]   start_span;
  logic [31:0]   start_base;
  logic          start_skip;
  logic [3:0]    cur_idx;
  logic [8:0]    clr_mask;
  logic [8:0]    rest;

  stack_list_pick u_pick (
    .list_rem (list),
    .idx      (cur_idx),
    .clr_mask (clr_mask)
  );

  assign rest       = list & ~clr_mask;
  assign start_list = {extra_i, reg_list_i};
  assign start_cnt  = popcount9(start_list);
  assign start_span = 32'(WORD_BYTES) * {28'd0, start_cnt};
  assign start_base = is_push_i ? (sp_i - start_span) : sp_i;

`ifdef STACK_ALIGN_CHECK_EN
  logic fault_q;
  logic misalign;
  assign misalign   = (sp_i[1:0] != 2'b00);
  assign start_skip = (start_cnt == 4'd0) || misalign;
  assign fault_o    = (state == S_DONE) && fault_q;
`else
  assign start_skip = (start_cnt == 4'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      list    <= '0;
      cnt     <= '0;
      is_push <= 1'b0;
      addr    <= '0;
      sp_base <= '0;
      data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            list    <= start_list;
            cnt     <= start_cnt;
            is_push <= is_push_i;
            sp_base <= start_base;
            addr    <= AW'(start_base);
            if (start_skip)     state <= S_DONE;
            else if (is_push_i) state <= S_RD;
            else                state <= S_MEM;
          end
        end
        S_RD:  state <= S_RDW;
        S_RDW: begin
          data  <= rd_data_i;
          state <= S_MEM;
        end
        S_MEM: begin
          if (mem_ack_i) begin
            addr <= addr + AW'(WORD_BYTES);
            if (is_push) begin
              list  <= rest;
              state <= (rest != 9'd0) ? S_RD : S_SPU;
            end else begin
              data  <= mem_rdata_i;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          list  <= rest;
          state <= (rest != 9'd0) ? S_MEM : S_SPU;
        end
        S_SPU:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STACK_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         fault_q <= 1'b0;
    else if (state == S_IDLE && start_i) fault_q <= misalign;
  end
`endif

  // Outputs decode from registered state only, so reset forces them all low.
  always_comb begin
    rd_sel_o    = '0;
    wr_en_o     = 1'b0;
    wr_sel_o    = '0;
    wr_data_o   = '0;
    sp_we_o     = 1'b0;
    sp_o        = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    pc_load_o   = 1'b0;
    pc_o        = '0;
    done_o      = 1'b0;
    busy_o      = (state != S_IDLE);
    case (state)
      S_RD, S_RDW: rd_sel_o = cur_idx;
      S_MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_push;
        mem_addr_o  = addr;
        mem_wdata_o = is_push ? data : 32'd0;
      end
      S_WB: begin
        if (cur_idx == REG_LR) begin
          pc_load_o = 1'b1;
          pc_o      = {data[31:1], 1'b0};
        end else begin
          wr_en_o   = 1'b1;
          wr_sel_o  = cur_idx;
          wr_data_o = data;
        end
      end
      S_SPU: begin
        sp_we_o = 1'b1;
        sp_o    = is_push ? sp_base : sp_base + 32'(WORD_BYTES) * {28'd0, cnt};
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Multi-cycle PUSH/POP sequencer directly upstream of the register file in the Thumb-subset core.
- On a decoded PUSH/POP it walks the 8-bit low-register list plus the LR/PC bit one register per iteration:
  - drives the register-file read select and write select/enable;
  - issues word accesses on the data-memory port;
  - commits the final SP through the register file's SP write port.
- Holds the pipeline stalled while busy.

Parameters:
- AW, 32, data-memory address width.
- WORD_BYTES, 4, SP step per transferred register.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle request from decode; sampled only in IDLE.
- is_push_i  input  1  1=PUSH, 0=POP; sampled with start_i.
- reg_list_i  input  8  r0..r7 select bits.
- extra_i  input  1  PUSH: also store LR (r14); POP: also load PC.
- sp_i  input  32  current SP value from the register file; sampled with start_i.
- rd_data_i  input  32  register-file data_out0.
- rd_sel_o  output  4  to register-file rd0_select.
- wr_en_o  output  1  to register-file write_en.
- wr_sel_o  output  4  to register-file wr_select.
- wr_data_o  output  32  to register-file data_in.
- sp_we_o  output  1  to register-file sp_write_en.
- sp_o  output  32  to register-file sp_in.
- mem_req_o  output  1  memory request, held until ack.
- mem_we_o  output  1  1=write.
- mem_addr_o  output  AW  word address in bytes.
- mem_wdata_o  output  32  store data.
- mem_ack_i  input  1  request completes in the cycle ack=1 while req=1.
- mem_rdata_i  input  32  load data, valid with ack on reads.
- pc_load_o  output  1  one-cycle pulse: POP loaded PC.
- pc_o  output  32  loaded PC value, valid with pc_load_o.
- busy_o  output  1  stall to fetch/decode.
- done_o  output  1  one-cycle pulse at completion.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, internal list/count/address 0.
- States: IDLE, RD, RDW, MEM, WB, SPU, DONE.
- IDLE, on start_i:
  - latch list = {extra_i, reg_list_i}, count = popcount (0..9), dir, base.
  - base = sp_i - WORD_BYTES*count for PUSH; base = sp_i for POP. Arithmetic is 32-bit modulo (wraps).
  - busy_o rises the next cycle.
  - count==0 -> DONE directly: no memory access, no SP write.
- Register order is always ascending: r0..r7, then r14/PC. The current register is the lowest set bit remaining. Address starts at base and increments by WORD_BYTES after each acked access.
- PUSH path:
  - RD: rd_sel_o = reg index (14 for the extra bit), one cycle.
  - RDW: the register file returns data one posedge later; capture rd_data_i, go to MEM.
  - MEM: mem_req_o=1, mem_we_o=1, addr/wdata stable until ack. On ack, clear the bit; go to RD if bits remain, else SPU.
- POP path:
  - MEM: read request; on ack capture mem_rdata_i, go to WB.
  - WB: for r0..r7, wr_en_o=1 for one cycle with wr_sel_o=index and wr_data_o=captured data. For the extra bit, pc_load_o=1 and pc_o=data[31:1]<<1; no regfile write.
  - Then MEM if bits remain, else SPU.
- SPU: sp_we_o=1 one cycle. sp_o = base for PUSH; sp_o = sp_i_latched + WORD_BYTES*count for POP.
- DONE: done_o=1 one cycle, busy_o=0 from next cycle, return to IDLE.
- start_i while not IDLE: ignored.
- Ack arriving in the same cycle req first rises: legal, 1-cycle access.
- Reset mid-operation: immediate abort to IDLE. SP is not written and partial stores are not undone.
- wr_en_o and sp_we_o are never high together.

Optional Feature:
- Macro: STACK_ALIGN_CHECK_EN.
- Defined: start with sp_i[1:0]!=0 goes to DONE without memory access or SP write. Adds output fault_o (1 bit), pulsed with done_o.
- Undefined: no check; fault_o is absent; the low address bits are passed through unchanged.

Decomposition:
- Package stack_pkg:
  - state enum;
  - REG_LR=4'hE, REG_SP=4'hD;
  - WORD_BYTES default;
  - function lowest_set(9-bit) -> index;
  - function popcount9.
- Sub-module stack_list_pick (combinational priority encoder): remaining list -> reg index plus one-hot clear mask.

Test Plan:
- PUSH {r0,r2,LR}, sp_i=0x1000, ack after 2 cycles -> writes 0x0FF4=r0, 0x0FF8=r2, 0x0FFC=lr in that order; sp_o=0x0FF4; one done_o pulse.
- POP {r1,PC}, sp_i=0x0FF8, mem holds 0xAAAA, 0x0203 -> r1=0xAAAA via wr_sel_o=1; pc_load_o with pc_o=0x0202; sp_o=0x1000.
- Empty list, start -> done_o 2 cycles after start; no mem_req_o; no sp_we_o.
- PUSH with 0-wait ack (ack tied 1) and full list 0xFF+LR -> 9 stores at ascending addresses; sp_o=sp_i-36.
- rst_n low during the 3rd store of a PUSH -> all outputs 0 immediately; no sp_we_o; next start_i accepted normally.
- With STACK_ALIGN_CHECK_EN, sp_i=0x1ffe -> fault_o and done_o pulse; no memory or SP activity.
